// File: rtl/ltc2324_pkg.sv
// Shared types and default timing for the LTC2324 conversion controller.
// Values are in 100 MHz clk cycles unless noted.
package ltc2324_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CNV   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_GAP   = 3'd4
   } state_e;

   localparam int CONV_PERIOD = 100;
   localparam int CNV_HIGH    = 3;
   localparam int CONV_WAIT   = 45;
   localparam int DATA_BITS   = 16;
   localparam int NUM_LANES   = 4;

endpackage

// File: rtl/ltc2324_lane_shift.sv
// One SDO lane: MSB-first shift register. data_nxt is the value the register
// takes on the coming edge, so the parent can capture the final bit in the same edge.
module ltc2324_lane_shift #(
   parameter int W = ltc2324_pkg::DATA_BITS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_en,
   input  logic         sdi,
   output logic [W-1:0] data_nxt
);

   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (shift_en) begin
         data_d = {data_q[W-2:0], sdi};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data_nxt = data_d;

endmodule

// File: rtl/ltc2324_ctrl.sv
// LTC2324 frame controller: CNV pulse, SCK burst, 4-lane capture, one-cycle valid.
// Define LTC2324_TESTPAT_EN to add the test_mode port and the counting test pattern.
module ltc2324_ctrl #(
   parameter int CONV_PERIOD = ltc2324_pkg::CONV_PERIOD,
   parameter int CNV_HIGH    = ltc2324_pkg::CNV_HIGH,
   parameter int CONV_WAIT   = ltc2324_pkg::CONV_WAIT,
   parameter int DATA_BITS   = ltc2324_pkg::DATA_BITS
) (
   input  logic                                       clk,
   input  logic                                       rst,
`ifdef LTC2324_TESTPAT_EN
   input  logic                                       test_mode,
`endif
   input  logic                                       pll_lock,
   input  logic                                       enable,
   output logic                                       cnv,
   output logic                                       sck,
   input  logic [ltc2324_pkg::NUM_LANES-1:0]          sdo,
   output logic [ltc2324_pkg::NUM_LANES*DATA_BITS-1:0] sample_data,
   output logic                                       sample_valid,
   output logic                                       busy
);

   import ltc2324_pkg::*;

   localparam int S0    = CNV_HIGH + CONV_WAIT;
   localparam int S_END = S0 + 2 * DATA_BITS;
   localparam int CNT_W = $clog2(CONV_PERIOD);
   localparam bit S0_PAR = 1'(S0 % 2);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t CNT_CNV_LAST   = cnt_t'(CNV_HIGH - 1);
   localparam cnt_t CNT_WAIT_LAST  = cnt_t'(S0 - 1);
   localparam cnt_t CNT_SHIFT_LAST = cnt_t'(S_END - 1);
   localparam cnt_t CNT_LAST       = cnt_t'(CONV_PERIOD - 1);

   if (CONV_PERIOD < S_END + 1 || CNV_HIGH < 1) begin : g_param_err
      $error("ltc2324_ctrl: CONV_PERIOD too short or CNV_HIGH < 1");
   end

   state_e state_q, state_d;
   cnt_t   cnt_q, cnt_d;
   logic   cnv_q, cnv_d;
   logic   sck_q, sck_d;
   logic   busy_q, busy_d;
   logic   valid_q, valid_d;
   logic [NUM_LANES*DATA_BITS-1:0] sample_data_q, sample_data_d;
   logic   load;
   logic   shift_en;
   logic [DATA_BITS-1:0] lane_nxt [NUM_LANES];

   // SDO is captured on the edge that ends each low half of SCK (odd offset).
   assign shift_en = (state_q == ST_SHIFT) && (cnt_q[0] != S0_PAR);

   for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
      ltc2324_lane_shift #(.W(DATA_BITS)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .shift_en (shift_en),
         .sdi      (sdo[n]),
         .data_nxt (lane_nxt[n])
      );
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (enable) state_d = ST_CNV;
         end
         ST_CNV: begin
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q == CNT_CNV_LAST) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q == CNT_WAIT_LAST) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            cnt_d = cnt_q + cnt_t'(1);
            if (cnt_q == CNT_SHIFT_LAST) begin
               state_d = ST_GAP;
               load    = 1'b1;
            end
         end
         ST_GAP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = enable ? ST_CNV : ST_IDLE;
            end else begin
               cnt_d = cnt_q + cnt_t'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Losing lock overrides everything, including a pending capture.
      if (!pll_lock) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         load    = 1'b0;
      end

      // Outputs are registered from the next state so they leave flops directly.
      cnv_d   = (state_d == ST_CNV);
      sck_d   = (state_d == ST_SHIFT) && (cnt_d[0] == S0_PAR);
      busy_d  = (state_d != ST_IDLE);
      valid_d = load;
   end

`ifdef LTC2324_TESTPAT_EN
   logic [DATA_BITS-3:0] fcnt_q, fcnt_d;

   always_comb begin
      sample_data_d = sample_data_q;
      fcnt_d        = fcnt_q;
      if (load) begin
         fcnt_d = fcnt_q + 1'b1;
         for (int n = 0; n < NUM_LANES; n++) begin
            sample_data_d[n*DATA_BITS +: DATA_BITS] =
               test_mode ? {fcnt_q, 2'(n)} : lane_nxt[n];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) fcnt_q <= '0;
      else     fcnt_q <= fcnt_d;
   end
`else
   always_comb begin
      sample_data_d = sample_data_q;
      if (load) begin
         for (int n = 0; n < NUM_LANES; n++) begin
            sample_data_d[n*DATA_BITS +: DATA_BITS] = lane_nxt[n];
         end
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cnv_q         <= 1'b0;
         sck_q         <= 1'b0;
         busy_q        <= 1'b0;
         valid_q       <= 1'b0;
         sample_data_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cnv_q         <= cnv_d;
         sck_q         <= sck_d;
         busy_q        <= busy_d;
         valid_q       <= valid_d;
         sample_data_q <= sample_data_d;
      end
   end

   assign cnv          = cnv_q;
   assign sck          = sck_q;
   assign busy         = busy_q;
   assign sample_valid = valid_q;
   assign sample_data  = sample_data_q;

endmodule

// File: doc/ltc2324_ctrl.md
# ltc2324_ctrl

Conversion controller and serial capture engine for the quad-channel 16-bit LTC2324 ADC. It runs on the 100 MHz PLL output and stays idle until the PLL reports lock. Each frame it generates the CNV pulse and a burst of SCK, then shifts in the four SDO lanes MSB first. It presents all four samples as one word with a single-cycle valid strobe to the downstream buffering logic.

## Interface
- CONV_PERIOD, 100: clk cycles per conversion frame (1 Msps at 100 MHz).
- CNV_HIGH, 3: clk cycles CNV is held high.
- CONV_WAIT, 45: clk cycles between CNV falling and the first SCK high.
- DATA_BITS, 16: bits per lane.
- clk  in  1  100 MHz system clock; the only clock in the block.
- rst  in  1  reset, asynchronous and active-high.
- pll_lock  in  1  PLL lock; treated as a level, already in the clk domain.
- enable  in  1  run request from the control register.
- cnv  out  1  ADC convert start.
- sck  out  1  ADC serial clock, clk/2 during shift.
- sdo  in  4  ADC serial data lanes; bit n is channel n.
- sample_data  out  4*DATA_BITS  channel n occupies bits [n*DATA_BITS +: DATA_BITS].
- sample_valid  out  1  one-cycle strobe; sample_data is new in this cycle.
- busy  out  1  high whenever the FSM is not IDLE.

## Operation
- FSM states are IDLE, CNV, WAIT, SHIFT and GAP.
- A frame counter cnt runs 0..CONV_PERIOD-1; cnt is 0 in the first CNV cycle.
- IDLE: cnv=0, sck=0. If pll_lock and enable are both high, go to CNV next cycle with cnt=0.
- CNV: cnv=1 for cnt 0..CNV_HIGH-1, then go to WAIT.
- WAIT: cnv=0 for CONV_WAIT cycles, then go to SHIFT. Define S0 = CNV_HIGH+CONV_WAIT.
- SHIFT: runs for 2*DATA_BITS cycles; the offset is k = cnt-S0.
  - sck=1 when k is even and sck=0 when k is odd.
  - Each lane's sdo is shifted into its lane register on the clk edge that ends an odd-k cycle.
  - Bits arrive MSB first.
- After the last bit, go to GAP.
  - sample_data is loaded from the lane registers and sample_valid=1, both in cycle cnt=S0+2*DATA_BITS.
- GAP: hold until cnt=CONV_PERIOD-1.
  - If enable and pll_lock are high, go to CNV with cnt=0.
  - Otherwise go to IDLE.
- Deasserting enable mid-frame: the current frame completes, including sample_valid, then the FSM goes to IDLE.
- pll_lock low in any state: the FSM aborts to IDLE on the next edge.
  - cnv and sck are forced to 0.
  - No sample_valid is issued for the partial frame.
  - sample_data keeps its last value.
- Parameter legality: CONV_PERIOD >= S0+2*DATA_BITS+1 and CNV_HIGH >= 1. A violation is an elaboration-time error.
- Reset: all outputs are 0, the FSM is in IDLE, and cnt and the lane registers are 0.

## Timing
- cnv, sck, sample_data, sample_valid and busy are all driven directly from flops. No combinational path from any input to any output.
- From IDLE with enable&pll_lock sampled high, cnv rises 1 cycle later.
- sample_valid comes S0+2*DATA_BITS cycles after cnv rises: 80 cycles at the defaults.
- Back-to-back frames: cnv rising edges are exactly CONV_PERIOD cycles apart.
- sample_valid pulses are exactly CONV_PERIOD cycles apart.
- The SCK burst is DATA_BITS high pulses, each 1 cycle high and 1 cycle low (50 MHz).
- sck is 0 outside SHIFT.

## Configuration
- LTC2324_TESTPAT_EN defined:
  - Adds an input port test_mode (1 bit).
  - When test_mode=1 at frame load, channel n of sample_data is loaded with {frame counter[DATA_BITS-3:0], n[1:0]} instead of the lane registers.
  - The frame counter is a DATA_BITS-2 bit counter that increments every sample_valid, wraps, and resets to 0.
  - cnv and sck timing are unchanged.
- LTC2324_TESTPAT_EN undefined: no test_mode port and no frame counter; sample_data always comes from the lane registers.

## Structure
- ltc2324_pkg holds:
  - the FSM state enum;
  - the default timing constants (CONV_PERIOD, CNV_HIGH, CONV_WAIT, DATA_BITS);
  - the lane count constant NUM_LANES=4.
- Sub-module ltc2324_lane_shift: a per-lane DATA_BITS shift register with a shift enable. It is instantiated NUM_LANES times in a generate loop.

## Test plan
- Release rst with pll_lock=1 and enable=1.
  - cnv rises 1 cycle after enable is sampled, is high for 3 cycles, and repeats every 100 cycles.
  - sck shows 16 pulses starting at cnt=48.
- ADC model drives lane n with 16'hA5C3+n, MSB first.
  - sample_valid at cnt=80.
  - sample_data = {16'hA5C6, 16'hA5C5, 16'hA5C4, 16'hA5C3}.
- Drop pll_lock at cnt=60 (mid-SHIFT).
  - Next cycle: cnv=0, sck=0, busy=0.
  - No sample_valid; sample_data is unchanged.
  - Restoring lock restarts a frame with cnt=0.
- Deassert enable at cnt=20.
  - The frame completes and sample_valid is seen at cnt=80.
  - busy falls at cnt=99 + 1; no further cnv.
- Assert rst asynchronously mid-WAIT: all outputs go to 0 immediately, without waiting for a clock edge.
- With LTC2324_TESTPAT_EN and test_mode=1: three consecutive frames give ch0 = 16'h0000, 16'h0004, 16'h0008 and ch3 = 16'h0003, 16'h0007, 16'h000B.
